// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher, one round per clock. Round keys are walked
// backwards from rk10, so only rk10 (optionally cached) needs to be kept.

module aes_gf_inv (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] sq;
  logic [7:0] acc;

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] p;
    logic [7:0] v;
    p = '0;
    v = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ v;
      v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); zero maps to zero
  always_comb begin
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    y = acc;
  end
endmodule

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] inv;

  aes_gf_inv u_inv (.a(a), .y(inv));

  assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] pre;

  assign pre = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;

  aes_gf_inv u_inv (.a(pre), .y(y));
endmodule

module aes_decrypt_iter #(
  parameter int KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] ciphertext,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic         done,
  output logic [2:0]   dbg_state
);
  // Handshake: start is taken on a rising edge only while busy=0; busy is high
  // from the next cycle until the result; done pulses one cycle with plaintext
  // valid and busy already low, so a new start may be presented in that cycle.

  typedef enum logic [2:0] {
    st_idle   = 3'd0,
    st_expand = 3'd1,
    st_init   = 3'd2,
    st_round  = 3'd3,
    st_final  = 3'd4
  } state_t;

  state_t       st_q, st_d;
  logic [3:0]   cnt_q;
  logic [7:0]   rcon_q;
  logic [127:0] blk_q, key_q, cache_key_q, cache_rk_q;
  logic         cache_vld_q;
  logic         cache_hit;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] xtime_inv(input logic [7:0] b);
    return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
  endfunction

  function automatic logic [7:0] mul_9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction
  function automatic logic [7:0] mul_b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction
  function automatic logic [7:0] mul_d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction
  function automatic logic [7:0] mul_e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Key schedule: one S-box word shared by the forward and backward steps
  logic [31:0]  w0, w1, w2, w3, sub_in, sub_out, t_word, fw0, fw1, fw2, fw3;
  logic [127:0] key_fwd, key_bwd;

  assign {w0, w1, w2, w3} = key_q;
  assign sub_in = (st_q == st_expand) ? w3 : (w3 ^ w2);

  for (genvar g = 0; g < 4; g++) begin : g_ksbox
    aes_sbox u_sbox (.a(sub_in[31-8*((g+1)%4) -: 8]), .y(sub_out[31-8*g -: 8]));
  end

  assign t_word  = sub_out ^ {rcon_q, 24'h0};
  assign fw0     = w0 ^ t_word;
  assign fw1     = w1 ^ fw0;
  assign fw2     = w2 ^ fw1;
  assign fw3     = w3 ^ fw2;
  assign key_fwd = {fw0, fw1, fw2, fw3};
  assign key_bwd = {w0 ^ t_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};

  // Round datapath: byte g sits at row g%4, column g/4
  logic [127:0] isr, isb, ark, imc;
  logic [7:0]   a0, a1, a2, a3;

  for (genvar g = 0; g < 16; g++) begin : g_round
    assign isr[127-8*g -: 8] = blk_q[127-8*(4*(((g/4)-(g%4)+4)%4)+(g%4)) -: 8];
    aes_inv_sbox u_isbox (.a(isr[127-8*g -: 8]), .y(isb[127-8*g -: 8]));
  end

  assign ark = isb ^ key_q;

  always_comb begin
    imc = '0;
    a0  = '0;
    a1  = '0;
    a2  = '0;
    a3  = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = ark[127-32*c -: 8];
      a1 = ark[119-32*c -: 8];
      a2 = ark[111-32*c -: 8];
      a3 = ark[103-32*c -: 8];
      imc[127-32*c -: 8] = mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3);
      imc[119-32*c -: 8] = mul_9(a0) ^ mul_e(a1) ^ mul_b(a2) ^ mul_d(a3);
      imc[111-32*c -: 8] = mul_d(a0) ^ mul_9(a1) ^ mul_e(a2) ^ mul_b(a3);
      imc[103-32*c -: 8] = mul_b(a0) ^ mul_d(a1) ^ mul_9(a2) ^ mul_e(a3);
    end
  end

  assign cache_hit = (KEY_CACHE != 0) && cache_vld_q && (key == cache_key_q);
  assign busy      = (st_q != st_idle);
  assign dbg_state = st_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_q <= st_idle;
    else      st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      st_idle:   if (start) st_d = cache_hit ? st_init : st_expand;
      st_expand: if (cnt_q == 4'd10) st_d = st_init;
      st_init:   st_d = st_round;
      st_round:  if (cnt_q == 4'd1) st_d = st_final;
      st_final:  st_d = st_idle;
      default:   st_d = st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      rcon_q      <= 8'h01;
      blk_q       <= '0;
      key_q       <= '0;
      cache_key_q <= '0;
      cache_rk_q  <= '0;
      cache_vld_q <= 1'b0;
      plaintext   <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st_q)
        st_idle: if (start) begin
          blk_q <= ciphertext;
          if (cache_hit) begin
            key_q  <= cache_rk_q;
            rcon_q <= 8'h36;
            cnt_q  <= 4'd0;
          end else begin
            key_q       <= key;
            rcon_q      <= 8'h01;
            cnt_q       <= 4'd1;
            cache_key_q <= key;
            cache_vld_q <= 1'b0;
          end
        end
        st_expand: begin
          key_q <= key_fwd;
          // rcon stays at 0x36 after the last step: INIT undoes that step first
          if (cnt_q == 4'd10) begin
            cache_rk_q  <= key_fwd;
            cache_vld_q <= 1'b1;
          end else begin
            cnt_q  <= cnt_q + 4'd1;
            rcon_q <= xtime(rcon_q);
          end
        end
        st_init: begin
          blk_q  <= blk_q ^ key_q;
          key_q  <= key_bwd;
          rcon_q <= xtime_inv(rcon_q);
          cnt_q  <= 4'd9;
        end
        st_round: begin
          blk_q  <= imc;
          key_q  <= key_bwd;
          rcon_q <= xtime_inv(rcon_q);
          cnt_q  <= cnt_q - 4'd1;
        end
        st_final: begin
          plaintext <= ark;
          done      <= 1'b1;
          cnt_q     <= 4'd0;
          rcon_q    <= 8'h01;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: directed FIPS-197 vectors, loopback against a
// forward-cipher model, start spam, mid-run reset and a no-cache instance.

module tb_aes_decrypt_iter;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_LB = 128'h0123456789abcdef123456789abcdef0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         start_nc = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] ciphertext = '0;
  logic [127:0] plaintext, plaintext_nc;
  logic         busy, done, busy_nc, done_nc;
  logic [2:0]   dbg, dbg_nc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [127:0] exp_q[$];
  logic [127:0] exp_nc_q[$];
  int           lat_q[$], acc_q[$], lat_nc_q[$], acc_nc_q[$];
  logic [127:0] m_e, m_e_nc;
  int           m_l, m_a, m_l_nc, m_a_nc;

  logic [2047:0] sbox_flat = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  aes_decrypt_iter #(.KEY_CACHE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .ciphertext(ciphertext),
    .plaintext(plaintext), .busy(busy), .done(done), .dbg_state(dbg)
  );

  aes_decrypt_iter #(.KEY_CACHE(0)) dut_nc (
    .clk(clk), .rst(rst), .start(start_nc), .key(key), .ciphertext(ciphertext),
    .plaintext(plaintext_nc), .busy(busy_nc), .done(done_nc), .dbg_state(dbg_nc)
  );

  // ---------------- forward cipher model for loopback ----------------
  function automatic logic [7:0] sb(input logic [7:0] x);
    return sbox_flat[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] s, rk, t;
    logic [31:0]  tw;
    logic [7:0]   rc, b0, b1, b2, b3;
    s  = p ^ k;
    rk = k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      tw = {sb(rk[23:16]), sb(rk[15:8]), sb(rk[7:0]), sb(rk[31:24])} ^ {rc, 24'h0};
      rk[127:96] = rk[127:96] ^ tw;
      rk[95:64]  = rk[95:64] ^ rk[127:96];
      rk[63:32]  = rk[63:32] ^ rk[95:64];
      rk[31:0]   = rk[31:0] ^ rk[63:32];
      rc = xt(rc);
      for (int i = 0; i < 16; i++)
        t[127-8*i -: 8] = sb(s[127-8*(4*(((i/4)+(i%4))%4)+(i%4)) -: 8]);
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          b0 = t[127-32*c -: 8];
          b1 = t[119-32*c -: 8];
          b2 = t[111-32*c -: 8];
          b3 = t[103-32*c -: 8];
          t[127-32*c -: 8] = xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
          t[119-32*c -: 8] = b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3;
          t[111-32*c -: 8] = b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3;
          t[103-32*c -: 8] = xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3);
        end
      end
      s = t ^ rk;
    end
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input bit nc);
    int n = 0;
    while ((nc ? busy_nc : busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (nc ? busy_nc : busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still high after %0d cycles, want low", n);
    end
  endtask

  task automatic issue(input bit nc, input logic [127:0] k, input logic [127:0] ct,
                       input logic [127:0] pt, input int lat);
    wait_idle(nc);
    key        = k;
    ciphertext = ct;
    if (nc) begin
      start_nc = 1'b1;
      exp_nc_q.push_back(pt);
      lat_nc_q.push_back(lat);
      acc_nc_q.push_back(cyc + 1);
    end else begin
      start = 1'b1;
      exp_q.push_back(pt);
      lat_q.push_back(lat);
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    start    = 1'b0;
    start_nc = 1'b0;
    check(nc ? "busy_after_accept_nc" : "busy_after_accept",
          128'(nc ? busy_nc : busy), 128'(1));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_nc_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || exp_nc_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d/%0d results outstanding, want 0",
               exp_q.size(), exp_nc_q.size());
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, want no done", cyc);
      end else begin
        m_e = exp_q.pop_front();
        m_l = lat_q.pop_front();
        m_a = acc_q.pop_front();
        check("plaintext", plaintext, m_e);
        check("latency", 128'(cyc - m_a), 128'(m_l));
        check("busy_at_done", 128'(busy), 128'(0));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && done_nc) begin
      if (exp_nc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done_nc: got done=1 at cycle %0d, want no done", cyc);
      end else begin
        m_e_nc = exp_nc_q.pop_front();
        m_l_nc = lat_nc_q.pop_front();
        m_a_nc = acc_nc_q.pop_front();
        check("plaintext_nc", plaintext_nc, m_e_nc);
        check("latency_nc", 128'(cyc - m_a_nc), 128'(m_l_nc));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [127:0] lb_pt, lb_ct, last_pt;

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_plaintext", plaintext, '0);
    check("reset_done", 128'(done), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_state", 128'(dbg), 128'(0));
    check("reset_plaintext_nc", plaintext_nc, '0);
    check("reset_busy_nc", 128'(busy_nc), 128'(0));
    check("reset_state_nc", 128'(dbg_nc), 128'(0));
    rst = 1'b1;
    @(negedge clk);

    issue(1'b0, KEY_C1, CT_C1, PT_C1, 21);
    issue(1'b0, KEY_B, CT_B, PT_B, 21);
    issue(1'b0, KEY_B, CT_B, PT_B, 11);

    // start held and inputs scrambled for the whole busy window
    issue(1'b0, KEY_C1, CT_C1, PT_C1, 21);
    for (int n = 0; n < 100 && busy; n++) begin
      start      = 1'b1;
      key        = {$urandom, $urandom, $urandom, $urandom};
      ciphertext = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    start = 1'b0;
    repeat (25) @(negedge clk);

    // abort a cache-hit run mid-round; the cache must be lost
    issue(1'b0, KEY_C1, CT_C1, PT_C1, 11);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    #1;
    check("abort_plaintext", plaintext, '0);
    check("abort_done", 128'(done), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(1'b0, KEY_C1, CT_C1, PT_C1, 21);

    lb_pt = '0;
    for (int i = 0; i < 1000; i++) begin
      lb_ct = aes_enc(KEY_LB, lb_pt);
      issue(1'b0, KEY_LB, lb_ct, lb_pt, (i == 0) ? 21 : 11);
      last_pt = lb_pt;
      lb_pt   = lb_ct;
    end
    drain();
    repeat (5) @(negedge clk);
    check("plaintext_hold", plaintext, last_pt);

    issue(1'b1, KEY_B, CT_B, PT_B, 21);
    issue(1'b1, KEY_B, CT_B, PT_B, 21);
    drain();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_decrypt_iter.md
# aes_decrypt_iter

Iterative AES-128 inverse cipher (FIPS-197 InvCipher) that computes one round per clock. It is the receive-side counterpart of the team's iterative `aes` encryptor and recovers plaintext from ciphertext produced under the same 128-bit key. The forward key schedule runs on the fly to reach round key 10. Round keys are then derived backwards during the inverse rounds, so there is no 11-entry key RAM. The block sits beside the encryptor in the crypto datapath, and its start/done handshake suits a loopback bench (encrypt, then decrypt, then compare).

## Interface
- `KEY_CACHE`, default 1: when 1, retain round key 10 and skip expansion if the new key equals the last expanded key.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, **asynchronous, active-low**.
- `start` input 1: request; accepted only when `busy`=0.
- `key` input 128: cipher key, byte 0 = bits [127:120]; sampled on accept.
- `ciphertext` input 128: block to decrypt, same byte order; sampled on accept.
- `plaintext` output 128: result; holds until the next `done`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when `plaintext` updates.

## Operation
- FSM states: IDLE, EXPAND, INIT, ROUND, FINAL.
- **IDLE**: when `start`=1, latch `key` into the key register and `ciphertext` into the state register; rcon = 0x01.
  - If KEY_CACHE=1, cache valid, and `key` equals the cached key: go to INIT and load the cached round key 10.
  - Otherwise go to EXPAND.
- **EXPAND**: 10 cycles.
  - Each cycle applies the forward expansion: RotWord, SubWord, xor rcon, then chained xor.
  - rcon steps 01,02,04,08,10,20,40,80,1b,36.
  - After cycle 10 the key register holds rk10. Store rk10 into the cache, set cache valid, go to INIT.
- **INIT**: 1 cycle.
  - state ← state ^ rk10.
  - Key register steps back to rk9 by inverse expansion: w[i-4] = w[i] ^ w[i+1-4]-chain, i.e. w0' = w0^SubWord(RotWord(w3'))^rcon, with w3'=w3^w2, w2'=w2^w1, w1'=w1^w0.
  - rcon runs in reverse: 36 down to 01.
  - Round counter = 9. Go to ROUND.
- **ROUND**: 9 cycles, rounds 9..1.
  - state ← InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_r).
  - Key register steps back one round each cycle.
  - Counter decrements. At counter = 1 go to FINAL.
- **FINAL**: 1 cycle.
  - `plaintext` ← InvSubBytes(InvShiftRows(state)) ^ rk0.
  - Pulse `done`. Go to IDLE.
- S-box lookups use the codebase's byte S-box and inverse S-box lookup modules, instantiated 4× and 16× respectively.
- All arithmetic is in GF(2^8) with polynomial 0x11b. InvMixColumns uses the xtime-based ×9, ×b, ×d, ×e.
- `start` while `busy`=1 is ignored; it is neither queued nor latched.
- Changes on `key` or `ciphertext` after accept have no effect.

## Timing
- Reset values:
  - `plaintext` = 0, `done` = 0, `busy` = 0.
  - State = IDLE, counter = 0, rcon = 0x01.
  - Cache invalid, cached key = 0.
- Reset asserted mid-operation aborts immediately and asynchronously to the reset values. No `done` follows.
- Accept happens at edge T0, where IDLE and `start` are both high. `busy`=1 from T0+1.
- Latency:
  - Cache miss: `done` high in cycle T0+21, covering 10 EXPAND, 1 INIT, 9 ROUND, 1 FINAL.
  - Cache hit: `done` high in cycle T0+11.
- `plaintext` is valid in the same cycle `done` is high. `busy` is 0 in that cycle.
- Back-to-back operation: `start` is accepted at the `done` edge. Minimum issue interval is 22 cycles on a miss and 12 cycles on a hit.
- With KEY_CACHE=0, every request takes the 21-cycle path.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a → plaintext 00112233445566778899aabbccddeeff, `done` exactly 21 cycles after accept.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 → plaintext 3243f6a8885a308d313198a2e0370734.
  - Repeat with the same key immediately: `done` after 11 cycles, same result.
- Loopback: chain 1000 blocks from `aes` with key 0123456789abcdef123456789abcdef0, initial plaintext 0, then decrypt each → every recovered block equals the corresponding encryptor input.
- `start` pulsed every cycle during busy, with `key`/`ciphertext` toggled → exactly one `done`, and the result matches the values latched at accept.
- Reset driven low at cycle T0+7 → all outputs 0 within the same cycle. Next request with the same key takes 21 cycles, because the cache is invalidated.
- KEY_CACHE=0, same key twice → both requests take 21 cycles with identical results.
